// File: rtl/uart_rx.sv
// 8N1 serial receiver driven by a 16x oversampling strobe.
// Recovered bytes go out on a valid/ready port, with framing-error and overrun pulses.
module uart_rx #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk_5m,
   input  logic                 rst_n,
   input  logic                 rxclk_en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t               state, state_nxt;
   logic [3:0]           tick_cnt, tick_nxt;
   logic [2:0]           bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 rx_meta, rx_s;
   logic                 good_frame, stop_bad;

   // synchronizer stage: rx is asynchronous to clk_5m
   always_ff @(posedge clk_5m or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk_5m or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tick_nxt   = tick_cnt;
      bit_nxt    = bit_cnt;
      shreg_nxt  = shreg;
      good_frame = 1'b0;
      stop_bad   = 1'b0;
      if (rxclk_en) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nxt = START;
                  tick_nxt  = '0;
               end
            end
            START: begin
               // half a bit in: confirm the start bit or reject it as a glitch
               if (tick_cnt != 4'd7) begin
                  tick_nxt = tick_cnt + 4'd1;
               end else if (!rx_s) begin
                  state_nxt = DATA;
                  tick_nxt  = '0;
                  bit_nxt   = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end
            DATA: begin
               if (tick_cnt != 4'd15) begin
                  tick_nxt = tick_cnt + 4'd1;
               end else begin
                  shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                  tick_nxt  = '0;
                  bit_nxt   = bit_cnt + 3'd1;
                  if (bit_cnt == 3'(DATA_BITS - 1)) begin
                     state_nxt = STOP;
                  end
               end
            end
            STOP: begin
               if (tick_cnt != 4'd15) begin
                  tick_nxt = tick_cnt + 4'd1;
               end else begin
                  tick_nxt = '0;
                  if (rx_s) begin
                     good_frame = 1'b1;
                     state_nxt  = IDLE;
                  end else begin
                     stop_bad  = 1'b1;
                     state_nxt = WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               // a held-low line (break) must return high before a new frame
               if (rx_s) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // output stage: a full holding register keeps its byte and drops the new one
   always_ff @(posedge clk_5m or negedge rst_n) begin
      if (!rst_n) begin
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= good_frame & valid & ~ready;
         if (good_frame && (!valid || ready)) begin
            data  <= shreg;
            valid <= 1'b1;
         end else if (!good_frame && valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus hand-written glitch, overrun,
// back-to-back and mid-frame reset sequences.
module tb_uart_rx;

   logic       clk_5m = 1'b0;
   logic       rst_n  = 1'b0;
   logic       rxclk_en = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       ready = 1'b0;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_pass = 0;
   int n_total = 0;
   logic [7:0] got[$];
   int ferr_cnt = 0;
   int ovr_cnt = 0;

   typedef struct {
      logic [7:0] payload;
      int         bclk;
      logic       stop;
      int         low_after;
      int         exp_n;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[4];

   uart_rx #(.DATA_BITS(8)) dut (
      .clk_5m   (clk_5m),
      .rst_n    (rst_n),
      .rxclk_en (rxclk_en),
      .rx       (rx),
      .data     (data),
      .valid    (valid),
      .ready    (ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk_5m = ~clk_5m;

   initial begin
      forever begin
         repeat (27) @(negedge clk_5m);
         rxclk_en = 1'b1;
         @(negedge clk_5m);
         rxclk_en = 1'b0;
      end
   end

   always @(negedge clk_5m) begin
      if (valid && ready) got.push_back(data);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic clear_mon();
      got.delete();
      ferr_cnt = 0;
      ovr_cnt = 0;
   endtask

   task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop);
      rx = 1'b0;
      repeat (bclk) @(negedge clk_5m);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (bclk) @(negedge clk_5m);
      end
      rx = stop;
      repeat (bclk) @(negedge clk_5m);
   endtask

   task automatic wait_idle(input string name, input int max_clk);
      for (int i = 0; i < max_clk && busy; i++) @(negedge clk_5m);
      check(name, busy, 1'b0);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 434, 1'b1, 0, 1, 0};
      vecs[1] = '{8'h5A, 448, 1'b1, 0, 1, 0};
      vecs[2] = '{8'h3C, 434, 1'b0, 2, 0, 1};
      vecs[3] = '{8'h81, 434, 1'b1, 0, 1, 0};

      // reset
      repeat (3) @(negedge clk_5m);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_data", data, 0);
      rst_n = 1'b1;
      repeat (1000) @(negedge clk_5m);
      check("idle_busy", busy, 0);
      check("idle_valid", valid, 0);

      // frame table, ready high
      ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         clear_mon();
         send_frame(vecs[v].payload, vecs[v].bclk, vecs[v].stop);
         if (vecs[v].low_after > 0) begin
            repeat (vecs[v].low_after * vecs[v].bclk) @(negedge clk_5m);
            check($sformatf("v%0d_busy_low", v), busy, 1);
            rx = 1'b1;
         end
         repeat (2 * vecs[v].bclk) @(negedge clk_5m);
         wait_idle($sformatf("v%0d_idle", v), 600);
         check($sformatf("v%0d_count", v), got.size(), vecs[v].exp_n);
         if (vecs[v].exp_n > 0)
            check($sformatf("v%0d_data", v), (got.size() > 0) ? got[0] : 9'h100, vecs[v].payload);
         check($sformatf("v%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
         check($sformatf("v%0d_ovr", v), ovr_cnt, 0);
      end

      // glitch: low for three ticks only
      clear_mon();
      rx = 1'b0;
      repeat (84) @(negedge clk_5m);
      check("glitch_busy", busy, 1);
      rx = 1'b1;
      wait_idle("glitch_idle", 9 * 28 + 4);
      repeat (100) @(negedge clk_5m);
      check("glitch_count", got.size(), 0);
      check("glitch_ferr", ferr_cnt, 0);

      // overrun
      clear_mon();
      ready = 1'b0;
      send_frame(8'h11, 434, 1'b1);
      repeat (434) @(negedge clk_5m);
      send_frame(8'h22, 434, 1'b1);
      repeat (434) @(negedge clk_5m);
      check("ovr_valid", valid, 1);
      check("ovr_data", data, 8'h11);
      check("ovr_pulses", ovr_cnt, 1);
      check("ovr_ferr", ferr_cnt, 0);
      ready = 1'b1;
      @(negedge clk_5m);
      ready = 1'b0;
      check("ovr_drain", valid, 0);

      // back-to-back
      clear_mon();
      ready = 1'b1;
      send_frame(8'h00, 434, 1'b1);
      send_frame(8'hFF, 434, 1'b1);
      repeat (434) @(negedge clk_5m);
      wait_idle("b2b_idle", 600);
      check("b2b_count", got.size(), 2);
      check("b2b_first", (got.size() > 0) ? got[0] : 9'h100, 8'h00);
      check("b2b_second", (got.size() > 1) ? got[1] : 9'h100, 8'hFF);
      check("b2b_flags", ferr_cnt + ovr_cnt, 0);

      // reset in bit 4 with a byte pending
      clear_mon();
      ready = 1'b0;
      send_frame(8'h33, 434, 1'b1);
      repeat (434) @(negedge clk_5m);
      check("mid_pre_valid", valid, 1);
      rx = 1'b0;
      repeat (434) @(negedge clk_5m);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         repeat (434) @(negedge clk_5m);
      end
      rx = 1'b1;
      repeat (217) @(negedge clk_5m);
      check("mid_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_valid", valid, 0);
      check("mid_busy", busy, 0);
      repeat (20) @(negedge clk_5m);
      rst_n = 1'b1;
      repeat (434) @(negedge clk_5m);
      ready = 1'b1;
      clear_mon();
      send_frame(8'h7E, 434, 1'b1);
      repeat (434) @(negedge clk_5m);
      wait_idle("post_idle", 600);
      check("post_count", got.size(), 1);
      check("post_data", (got.size() > 0) ? got[0] : 9'h100, 8'h7E);
      check("post_flags", ferr_cnt + ovr_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
